// File: rtl/romboard_pkg.sv
// Shared types and constants for the CPC ROM board controller.
package romboard_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDrive
  } state_e;

  localparam int unsigned SEL_W      = 8;
  localparam int unsigned BANK_W     = 5;
  localparam logic [4:0]  LOWER_BANK = 5'd16;
  localparam logic        IO_SEL_A13 = 1'b0;

endpackage

// File: rtl/romboard_ctrl_if.sv
// CPC-side bus and flash/buffer control signals of the ROM board.
interface romboard_ctrl_if;
  logic [15:0] A;
  logic [7:0]  D;
  logic        IOREQ_B;
  logic        WR_B;
  logic        ROMEN_B;
  logic        ROMDIS;
  logic        bufoe_b;
  logic        flash_oe_b;
  logic [18:0] flash_addr;

  modport master (
    output A, D, IOREQ_B, WR_B, ROMEN_B,
    input  ROMDIS, bufoe_b, flash_oe_b, flash_addr
  );

  modport slave (
    input  A, D, IOREQ_B, WR_B, ROMEN_B,
    output ROMDIS, bufoe_b, flash_oe_b, flash_addr
  );
endinterface

// File: rtl/romboard_sync2.sv
// Two-flop synchronizer for an active-low strobe; resets to the inactive level.
module romboard_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/romboard_ctrl.sv
// CPC expansion ROM board controller: ROM-select latch, hit decode and flash access FSM.
module romboard_ctrl
  import romboard_pkg::*;
#(
  parameter logic [15:0] VALID_MASK = 16'h0001,
  parameter logic        LOWER_EN   = 1'b0,
  parameter int unsigned ACCESS_CYC = 3
) (
  input  logic           CLK,
  input  logic           RESET,
  romboard_ctrl_if.slave bus
);
  localparam logic [3:0] CntLoad = 4'(ACCESS_CYC - 1);

  logic w_ioreq_s;
  logic w_wr_s;
  logic w_romen_s;

  romboard_sync2 u_sync_ioreq (.i_clk(CLK), .i_rst(RESET), .i_d(bus.IOREQ_B), .o_q(w_ioreq_s));
  romboard_sync2 u_sync_wr    (.i_clk(CLK), .i_rst(RESET), .i_d(bus.WR_B),    .o_q(w_wr_s));
  romboard_sync2 u_sync_romen (.i_clk(CLK), .i_rst(RESET), .i_d(bus.ROMEN_B), .o_q(w_romen_s));

  state_e              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [BANK_W-1:0]   r_bank;
  logic [3:0]          r_cnt;
  logic                r_iow_prev;
  logic                r_armed;
  logic                r_romdis;
  logic                r_bufoe_b;
  logic                r_flash_oe_b;
  logic [18:0]         r_flash_addr;

  logic                w_iow;
  logic                w_io_sel;
  logic                w_sel_ok;
  logic                w_hit;
  logic [BANK_W-1:0]   w_bank;

  assign w_iow    = w_ioreq_s | w_wr_s;
  assign w_io_sel = r_iow_prev & ~w_iow & (bus.A[13] == IO_SEL_A13);
  assign w_sel_ok = (r_sel[SEL_W-1:4] == '0) && VALID_MASK[r_sel[3:0]];
  // r_armed records ROMEN_B high during the previous idle cycle, so a held strobe never retriggers
  assign w_hit    = ~w_romen_s & r_armed &
                    ((bus.A[14] & w_sel_ok) | (~bus.A[14] & LOWER_EN));
  assign w_bank   = bus.A[14] ? {1'b0, r_sel[3:0]} : LOWER_BANK;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= StIdle;
      r_sel        <= '0;
      r_bank       <= '0;
      r_cnt        <= '0;
      r_iow_prev   <= 1'b1;
      r_armed      <= 1'b0;
      r_romdis     <= 1'b0;
      r_bufoe_b    <= 1'b1;
      r_flash_oe_b <= 1'b1;
      r_flash_addr <= '0;
    end else begin
      r_iow_prev <= w_iow;
      if (w_io_sel) r_sel <= bus.D;

      unique case (r_state)
        StIdle: begin
          r_armed <= w_romen_s;
          if (w_hit) begin
            r_state      <= StAccess;
            r_bank       <= w_bank;
            r_cnt        <= CntLoad;
            r_romdis     <= 1'b1;
            r_flash_oe_b <= 1'b0;
            r_flash_addr <= {w_bank, bus.A[13:0]};
          end
        end
        StAccess, StDrive: begin
          r_armed <= 1'b0;
          if (w_romen_s) begin
            r_state      <= StIdle;
            r_romdis     <= 1'b0;
            r_bufoe_b    <= 1'b1;
            r_flash_oe_b <= 1'b1;
            r_flash_addr <= '0;
          end else begin
            r_flash_addr <= {r_bank, bus.A[13:0]};
            if (r_state == StAccess) begin
              if (r_cnt == 4'd0) begin
                r_state   <= StDrive;
                r_bufoe_b <= 1'b0;
              end else begin
                r_cnt <= r_cnt - 4'd1;
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.ROMDIS     = r_romdis;
  assign bus.bufoe_b    = r_bufoe_b;
  assign bus.flash_oe_b = r_flash_oe_b;
  assign bus.flash_addr = r_flash_addr;
endmodule
